// File: rtl/led_pattern_seq.sv
// led_pattern_seq: button-selectable animated pattern generator for the five user LEDs.
// The input path is a push-button synchronizer and debouncer. A step prescaler sets the
// animation rate. A four-mode sequencer FSM produces the pattern, and the LED outputs are
// registered.
// Optional macro LEDSEQ_PWM_EN adds a 4-bit brightness input and a PWM gate on the LEDs.
module led_pattern_seq #(
  parameter int STEP_DIV  = 3000000,
  parameter int DB_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       en,
  output logic [1:0] mode,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4
`ifdef LEDSEQ_PWM_EN
  ,
  input  logic [3:0] bright
`endif
);

  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  localparam logic [4:0] SEED_STATIC = 5'b10101;
  localparam logic [4:0] SEED_SHIFT  = 5'b00001;
  localparam logic [4:0] SEED_BOUNCE = 5'b00001;
  localparam logic [4:0] SEED_BLINK  = 5'b11111;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_BLINK  = 2'd3
  } state_t;

  // Button synchronizer and debouncer.
  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [DW-1:0] r_db_cnt;
  logic          r_btn_stable;
  logic          r_btn_prev;
  logic          r_btn_evt;

  // Sequencer state.
  state_t        r_state;
  logic [4:0]    r_pat;
  logic          r_dir;
  logic [PW-1:0] r_presc;

  // Next-state values.
  state_t        w_state_nxt;
  logic [4:0]    w_pat_nxt;
  logic          w_dir_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick;
  logic [4:0]    w_led;

  // Returns the pattern loaded when a mode is entered.
  function automatic logic [4:0] seed_of(input state_t s);
    logic [4:0] v;
    case (s)
      ST_STATIC: v = SEED_STATIC;
      ST_SHIFT:  v = SEED_SHIFT;
      ST_BOUNCE: v = SEED_BOUNCE;
      default:   v = SEED_BLINK;
    endcase
    return v;
  endfunction

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= btn;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // The stable level follows the synced level only after it has differed for DB_CYCLES
  // consecutive cycles. Any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt     <= '0;
      r_btn_stable <= 1'b0;
    end else if (r_sync_p1 != r_btn_stable) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_stable <= r_sync_p1;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Registered rising-edge detect of the debounced level. A release produces no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 1'b0;
      r_btn_evt  <= 1'b0;
    end else begin
      r_btn_prev <= r_btn_stable;
      r_btn_evt  <= r_btn_stable & ~r_btn_prev;
    end
  end

  // Sequencer state register: mode, pattern, bounce direction and step prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STATIC;
      r_pat   <= SEED_STATIC;
      r_dir   <= DIR_UP;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_dir   <= w_dir_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // Next-state logic. A button event takes priority and swallows a coincident tick.
  always_comb begin
    w_tick      = en && (r_presc == PRESC_LAST);
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_dir_nxt   = r_dir;
    w_presc_nxt = r_presc;

    if (en) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + PW'(1));
    end

    if (r_btn_evt) begin
      case (r_state)
        ST_STATIC: w_state_nxt = ST_SHIFT;
        ST_SHIFT:  w_state_nxt = ST_BOUNCE;
        ST_BOUNCE: w_state_nxt = ST_BLINK;
        default:   w_state_nxt = ST_STATIC;
      endcase
      w_pat_nxt   = seed_of(w_state_nxt);
      w_dir_nxt   = DIR_UP;
      w_presc_nxt = '0;
    end else if (w_tick) begin
      case (r_state)
        ST_SHIFT: begin
          w_pat_nxt = {r_pat[3:0], r_pat[4]};
        end
        ST_BOUNCE: begin
          // The end positions turn around immediately, so each end is lit for one step only.
          if (r_dir == DIR_UP) begin
            if (r_pat == 5'b10000) begin
              w_dir_nxt = DIR_DOWN;
              w_pat_nxt = 5'b01000;
            end else begin
              w_pat_nxt = {r_pat[3:0], 1'b0};
            end
          end else begin
            if (r_pat == 5'b00001) begin
              w_dir_nxt = DIR_UP;
              w_pat_nxt = 5'b00010;
            end else begin
              w_pat_nxt = {1'b0, r_pat[4:1]};
            end
          end
        end
        ST_BLINK: begin
          w_pat_nxt = ~r_pat;
        end
        default: begin
          w_pat_nxt = r_pat;
        end
      endcase
    end
  end

`ifdef LEDSEQ_PWM_EN
  logic [3:0] r_pwm_cnt;
  logic [4:0] r_led;

  // Free-running PWM counter. The LED register gates the next pattern with the duty compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 4'd0;
      r_led     <= SEED_STATIC;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      r_led     <= w_pat_nxt & {5{r_pwm_cnt < bright}};
    end
  end

  assign w_led = r_led;
`else
  assign w_led = r_pat;
`endif

  assign mode = r_state;
  assign LED0 = w_led[0];
  assign LED1 = w_led[1];
  assign LED2 = w_led[2];
  assign LED3 = w_led[3];
  assign LED4 = w_led[4];

endmodule
